// File: rtl/generic_serializer.sv
// Transmit end of the narrow serdes link: packs one 122-bit channel bundle into a 124-bit word
// and sends it LSB-first as FLIT_W-bit flits. Optional assertions: GENERIC_SERIALIZER_ASSERT_EN.
module generic_serializer #(
  parameter int FLIT_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [2:0]        io_in_bits_chanId,
  input  logic [2:0]        io_in_bits_opcode,
  input  logic [2:0]        io_in_bits_param,
  input  logic [3:0]        io_in_bits_size,
  input  logic [3:0]        io_in_bits_source,
  input  logic [31:0]       io_in_bits_address,
  input  logic [63:0]       io_in_bits_data,
  input  logic              io_in_bits_corrupt,
  input  logic [7:0]        io_in_bits_union,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [FLIT_W-1:0] io_out_bits
);

  localparam int WORD_W    = 124;
  localparam int NUM_FLITS = WORD_W / FLIT_W;
  // 5 bits covers the default 31 flits; narrower flits need a wider counter.
  localparam int CNT_W     = ($clog2(NUM_FLITS) > 5) ? $clog2(NUM_FLITS) : 5;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]        state;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  flit_count;
  logic              in_fire;
  logic              out_fire;
  logic              last_flit;

  // Pad bits at both ends bring the 122-bit bundle up to a multiple of every legal flit width.
  assign word = {1'b0, io_in_bits_chanId, io_in_bits_opcode, io_in_bits_param,
                 io_in_bits_size, io_in_bits_source, io_in_bits_address,
                 io_in_bits_data, io_in_bits_corrupt, io_in_bits_union, 1'b0};

  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == SEND);
  assign io_out_bits  = shift[FLIT_W-1:0];

  assign in_fire   = io_in_valid && io_in_ready;
  assign out_fire  = io_out_valid && io_out_ready;
  assign last_flit = (flit_count == CNT_W'(NUM_FLITS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift      <= '0;
      flit_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            shift      <= word;
            flit_count <= '0;
            state      <= SEND;
          end
        end
        default: begin
          if (out_fire) begin
            shift <= shift >> FLIT_W;
            if (last_flit) begin
              flit_count <= '0;
              state      <= IDLE;
            end else begin
              flit_count <= flit_count + 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef GENERIC_SERIALIZER_ASSERT_EN
`ifndef STOP_COND_
`define STOP_COND_ 1
`endif
  a_hold_bits: assert property (@(posedge clock) disable iff (!reset)
    (io_out_valid && !io_out_ready) |=> $stable(io_out_bits))
    else begin $error("io_out_bits changed under backpressure"); if (`STOP_COND_) $stop; end

  a_no_accept_in_send: assert property (@(posedge clock) disable iff (!reset)
    (state == SEND) |-> !in_fire)
    else begin $error("bundle accepted while sending"); if (`STOP_COND_) $stop; end

  a_count_range: assert property (@(posedge clock) disable iff (!reset)
    flit_count < CNT_W'(NUM_FLITS))
    else begin $error("flit_count out of range"); if (`STOP_COND_) $stop; end

  a_pad_clear: assert property (@(posedge clock) disable iff (!reset)
    in_fire |=> !shift[WORD_W-1])
    else begin $error("upper pad bit set at capture"); if (`STOP_COND_) $stop; end
`endif

endmodule

// File: tb/tb_generic_serializer.sv
// Self-checking bench for generic_serializer: behavioural packer/deserializer model with a
// per-cycle compare process, directed scenarios, and a randomized loopback run.
module tb_generic_serializer;

  localparam int NUM_FLITS = 31;

  typedef struct packed {
    logic [2:0]  ch;
    logic [2:0]  op;
    logic [2:0]  pm;
    logic [3:0]  sz;
    logic [3:0]  src;
    logic [31:0] addr;
    logic [63:0] data;
    logic        cor;
    logic [7:0]  un;
  } bundle_t;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [2:0]  io_in_bits_chanId;
  logic [2:0]  io_in_bits_opcode;
  logic [2:0]  io_in_bits_param;
  logic [3:0]  io_in_bits_size;
  logic [3:0]  io_in_bits_source;
  logic [31:0] io_in_bits_address;
  logic [63:0] io_in_bits_data;
  logic        io_in_bits_corrupt;
  logic [7:0]  io_in_bits_union;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [3:0]  io_out_bits;

  generic_serializer #(.FLIT_W(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_bits_chanId  (io_in_bits_chanId),
    .io_in_bits_opcode  (io_in_bits_opcode),
    .io_in_bits_param   (io_in_bits_param),
    .io_in_bits_size    (io_in_bits_size),
    .io_in_bits_source  (io_in_bits_source),
    .io_in_bits_address (io_in_bits_address),
    .io_in_bits_data    (io_in_bits_data),
    .io_in_bits_corrupt (io_in_bits_corrupt),
    .io_in_bits_union   (io_in_bits_union),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_bits        (io_out_bits)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_rdy = 0;

  // model state
  bit           busy = 0;
  int           sent = 0;
  logic [123:0] exp_word = '0;
  bundle_t      exp_b;
  logic [123:0] rx_word = '0;
  logic [123:0] last_word = '0;
  int           acc_count = 0;
  int           done_count = 0;
  int           t_acc = 0;
  int           t_acc_prev = 0;
  int           t_last = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [123:0] pack(input bundle_t b);
    logic [123:0] w;
    w = '0;
    w[1 +: 8]   = b.un;
    w[9]        = b.cor;
    w[10 +: 64] = b.data;
    w[74 +: 32] = b.addr;
    w[106 +: 4] = b.src;
    w[110 +: 4] = b.sz;
    w[114 +: 3] = b.pm;
    w[117 +: 3] = b.op;
    w[120 +: 3] = b.ch;
    return w;
  endfunction

  function automatic bundle_t unpack(input logic [123:0] w);
    bundle_t b;
    b.un   = w[1 +: 8];
    b.cor  = w[9];
    b.data = w[10 +: 64];
    b.addr = w[74 +: 32];
    b.src  = w[106 +: 4];
    b.sz   = w[110 +: 4];
    b.pm   = w[114 +: 3];
    b.op   = w[117 +: 3];
    b.ch   = w[120 +: 3];
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.ch   = 3'($urandom_range(0, 7));
    b.op   = 3'($urandom_range(0, 7));
    b.pm   = 3'($urandom_range(0, 7));
    b.sz   = 4'($urandom_range(0, 15));
    b.src  = 4'($urandom_range(0, 15));
    b.addr = $urandom;
    b.data = {$urandom, $urandom};
    b.cor  = 1'($urandom_range(0, 1));
    b.un   = 8'($urandom_range(0, 255));
    return b;
  endfunction

  function automatic bundle_t port_bundle();
    bundle_t b;
    b = '{io_in_bits_chanId, io_in_bits_opcode, io_in_bits_param, io_in_bits_size,
          io_in_bits_source, io_in_bits_address, io_in_bits_data, io_in_bits_corrupt,
          io_in_bits_union};
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    io_in_bits_chanId  = b.ch;
    io_in_bits_opcode  = b.op;
    io_in_bits_param   = b.pm;
    io_in_bits_size    = b.sz;
    io_in_bits_source  = b.src;
    io_in_bits_address = b.addr;
    io_in_bits_data    = b.data;
    io_in_bits_corrupt = b.cor;
    io_in_bits_union   = b.un;
  endtask

  // Compare process: outputs are stable at the falling edge; the model then advances by the
  // handshakes that the next rising edge will register.
  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_in_ready", io_in_ready, 1);
      chk("rst_out_valid", io_out_valid, 0);
      chk("rst_out_bits", io_out_bits, 0);
      busy = 0;
      sent = 0;
    end else begin
      chk("in_ready", io_in_ready, !busy);
      chk("out_valid", io_out_valid, busy);
      if (busy) begin
        chk("flit", io_out_bits, exp_word[sent*4 +: 4]);
        if (io_out_ready) begin
          rx_word[sent*4 +: 4] = io_out_bits;
          sent++;
          if (sent == NUM_FLITS) begin
            busy = 0;
            t_last = cyc;
            last_word = rx_word;
            done_count++;
            chk("pad_lo", rx_word[0], 0);
            chk("pad_hi", rx_word[123], 0);
            chk("loopback", unpack(rx_word), exp_b);
          end
        end
      end else if (io_in_valid) begin
        busy = 1;
        sent = 0;
        rx_word = '0;
        exp_b = port_bundle();
        exp_word = pack(exp_b);
        t_acc_prev = t_acc;
        t_acc = cyc;
        acc_count++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_rdy) io_out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_acc(input int target);
    int k = 0;
    while (acc_count < target && k < 3000) begin step(); k++; end
    chk("accept_timeout", acc_count >= target, 1);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_count < target && k < 3000) begin step(); k++; end
    chk("done_timeout", done_count >= target, 1);
  endtask

  task automatic wait_sent(input int n);
    int k = 0;
    while (!(busy && sent == n) && k < 200) begin step(); k++; end
    chk("flit_idx_timeout", busy && sent == n, 1);
  endtask

  bundle_t      b1;
  bundle_t      bx;
  logic [123:0] pkt1;

  initial begin
    reset = 1'b0;
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    drive('0);
    b1 = '{3'd5, 3'd4, 3'd0, 4'd3, 4'hA, 32'h8000_1234, 64'hDEAD_BEEF_0123_4567, 1'b0, 8'hFF};

    repeat (3) step();
    chk("reset_in_ready", io_in_ready, 1);
    chk("reset_out_valid", io_out_valid, 0);
    chk("reset_out_bits", io_out_bits, 0);
    reset = 1'b1;
    repeat (2) step();

    // single bundle, sink always ready
    drive(b1);
    io_in_valid = 1'b1;
    wait_acc(1);
    io_in_valid = 1'b0;
    drive(rand_bundle());
    wait_done(1);
    chk("s1_flit0", last_word[3:0], 4'hE);
    chk("s1_flit1", last_word[7:4], 4'hF);
    chk("s1_flit2", last_word[11:8], 4'hD);
    chk("s1_flit30", last_word[123:120], 4'h5);
    chk("s1_last_fire", t_last - t_acc, 31);
    chk("s1_ready_back", io_in_ready, 1);
    chk("s1_ready_cycle", cyc - t_acc, 32);
    pkt1 = last_word;

    // five-cycle stall on flit 10
    drive(b1);
    io_in_valid = 1'b1;
    wait_acc(2);
    io_in_valid = 1'b0;
    drive(rand_bundle());
    wait_sent(10);
    io_out_ready = 1'b0;
    repeat (5) step();
    io_out_ready = 1'b1;
    wait_done(2);
    chk("bp_last_fire", t_last - t_acc, 36);
    chk("bp_same_flits", last_word, pkt1);

    // back-to-back with valid held high
    drive(rand_bundle());
    io_in_valid = 1'b1;
    wait_acc(3);
    drive(rand_bundle());
    wait_acc(4);
    io_in_valid = 1'b0;
    chk("b2b_accept_gap", t_acc - t_acc_prev, 32);
    chk("b2b_after_last", t_acc - t_last, 1);
    drive(rand_bundle());
    wait_done(4);

    // reset during flit 15
    drive(rand_bundle());
    io_in_valid = 1'b1;
    wait_acc(5);
    io_in_valid = 1'b0;
    wait_sent(15);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", io_out_valid, 0);
    chk("mid_rst_in_ready", io_in_ready, 1);
    chk("mid_rst_out_bits", io_out_bits, 0);
    step();
    reset = 1'b1;
    step();
    bx = rand_bundle();
    bx.un = 8'h01;
    drive(bx);
    io_in_valid = 1'b1;
    wait_acc(6);
    io_in_valid = 1'b0;
    wait_done(5);
    chk("post_rst_flit0", last_word[3:0], 4'h2);

    // randomized loopback with sink stalls and source gaps
    rand_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      drive(rand_bundle());
      io_in_valid = 1'b1;
      wait_acc(7 + i);
      io_in_valid = 1'b0;
      drive(rand_bundle());
      repeat ($urandom_range(0, 3)) step();
    end
    rand_rdy = 0;
    io_out_ready = 1'b1;
    wait_done(105);
    chk("rand_all_done", done_count, 105);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
